// File: rtl/el2_pkg.sv
// Shared EL2 decode package.
// Holds the per-entry state record of the non-blocking load scoreboard and
// the upper bound on the number of outstanding load tags.
package el2_pkg;

   localparam int unsigned NBLOAD_TAGS_MAX = 8;

   // One outstanding non-blocking load.
   //   valid : allocated, return not yet consumed
   //   live  : GPR write still owed (cleared by a younger writer of rd)
   //   rd    : destination register
   typedef struct packed {
      logic       valid;
      logic       live;
      logic [4:0] rd;
   } el2_nbload_entry_t;

endpackage

// File: rtl/el2_dec_nbload_entry.sv
// One non-blocking load scoreboard entry.
// Holds valid/live/rd for one tag and produces the rd comparisons used by the
// top level for the stall tree and the writeback decision.
// Ports:
//   clk, rst           : clock, async active-high reset
//   alloc_sel          : allocation targets this entry
//   alloc_valid/rd     : any allocation this cycle (for alloc WAW kill)
//   wb_valid/wb_rd     : main pipe GPR write (for WAW kill)
//   ret_sel/cancel_sel : return/cancel tag decodes to this entry
//   raddr0/1           : decode source registers
//   ent                : current entry state
//   ret_hit/cancel_hit : return/cancel accepted by this (valid) entry
//   ret_write          : accepted return must write the GPR file
//   rd_hit0/1          : live entry matches a source register
module el2_dec_nbload_entry
   import el2_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_sel,
   input  logic              alloc_valid,
   input  logic [4:0]        alloc_rd,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd,
   input  logic              ret_sel,
   input  logic              cancel_sel,
   input  logic [4:0]        raddr0,
   input  logic [4:0]        raddr1,
   output el2_nbload_entry_t ent,
   output logic              ret_hit,
   output logic              cancel_hit,
   output logic              ret_write,
   output logic              rd_hit0,
   output logic              rd_hit1
);

   el2_nbload_entry_t ent_q, ent_d;
   logic              waw_wb, waw_alloc, waw;

   always_comb begin
      waw_wb     = wb_valid & (wb_rd != 5'd0) & (wb_rd == ent_q.rd);
      // An allocation to this same tag is a reuse, not a younger writer.
      waw_alloc  = alloc_valid & ~alloc_sel & (alloc_rd == ent_q.rd);
      waw        = ent_q.valid & (waw_wb | waw_alloc);
      ret_hit    = ret_sel & ent_q.valid;
      cancel_hit = cancel_sel & ent_q.valid & ~ret_hit;
      ret_write  = ret_hit & ent_q.live & ~waw;
      // live implies rd != 0, so x0 never matches here.
      rd_hit0    = ent_q.live & (ent_q.rd == raddr0);
      rd_hit1    = ent_q.live & (ent_q.rd == raddr1);
   end

   // Priority on a single tag: ret > cancel > alloc > WAW kill.
   always_comb begin
      ent_d = ent_q;
      if (ret_hit || cancel_hit) begin
         ent_d.valid = 1'b0;
         ent_d.live  = 1'b0;
      end else if (alloc_sel) begin
         ent_d.valid = 1'b1;
         ent_d.live  = (alloc_rd != 5'd0);
         ent_d.rd    = alloc_rd;
      end else if (waw) begin
         ent_d.live  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d;
      end
   end

   assign ent = ent_q;

endmodule

// File: rtl/el2_dec_nbload_scbd.sv
// Non-blocking load scoreboard and GPR writeback stage.
// Tracks outstanding loads by tag, stalls decode on operand hazards against
// pending live destinations, and writes returned load data to the GPR file
// through a registered write port. Returns whose destination was overwritten
// by a younger instruction are dropped.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   alloc_valid/tag/rd           : allocate an entry for an issued load
//   wb_valid/wb_rd               : main pipe GPR write (WAW kill)
//   cancel_valid/tag             : free an entry without writing
//   ret_valid/tag/data           : load data return
//   rden0/1, raddr0/1            : decode source operands
//   stall                        : operand hazard (combinational)
//   full                         : every entry valid
//   gpr_wen/gpr_waddr/gpr_wd     : registered GPR write port
//   bad_ret                      : sticky, return/cancel to an invalid tag
module el2_dec_nbload_scbd
   import el2_pkg::*;
#(
   parameter int NUM_TAGS = 4,
   parameter int TAG_W    = $clog2(NUM_TAGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   input  logic [TAG_W-1:0] alloc_tag,
   input  logic [4:0]       alloc_rd,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic             cancel_valid,
   input  logic [TAG_W-1:0] cancel_tag,
   input  logic             ret_valid,
   input  logic [TAG_W-1:0] ret_tag,
   input  logic [31:0]      ret_data,
   input  logic             rden0,
   input  logic             rden1,
   input  logic [4:0]       raddr0,
   input  logic [4:0]       raddr1,
   output logic             stall,
   output logic             full,
   output logic             gpr_wen,
   output logic [4:0]       gpr_waddr,
   output logic [31:0]      gpr_wd,
   output logic             bad_ret
);

   if (NUM_TAGS < 2 || NUM_TAGS > NBLOAD_TAGS_MAX || (NUM_TAGS & (NUM_TAGS - 1)) != 0)
   begin : g_bad_num_tags
      $error("el2_dec_nbload_scbd: NUM_TAGS must be a power of 2 in 2..8");
   end

   el2_nbload_entry_t ent [NUM_TAGS];
   logic [NUM_TAGS-1:0] valid_vec, ret_hit, cancel_hit, ret_write, rd_hit0, rd_hit1;

   for (genvar i = 0; i < NUM_TAGS; i++) begin : g_entry
      el2_dec_nbload_entry u_entry (
         .clk        (clk),
         .rst        (rst),
         .alloc_sel  (alloc_valid & (alloc_tag == TAG_W'(i))),
         .alloc_valid(alloc_valid),
         .alloc_rd   (alloc_rd),
         .wb_valid   (wb_valid),
         .wb_rd      (wb_rd),
         .ret_sel    (ret_valid & (ret_tag == TAG_W'(i))),
         .cancel_sel (cancel_valid & (cancel_tag == TAG_W'(i))),
         .raddr0     (raddr0),
         .raddr1     (raddr1),
         .ent        (ent[i]),
         .ret_hit    (ret_hit[i]),
         .cancel_hit (cancel_hit[i]),
         .ret_write  (ret_write[i]),
         .rd_hit0    (rd_hit0[i]),
         .rd_hit1    (rd_hit1[i])
      );
      assign valid_vec[i] = ent[i].valid;
   end

   logic        gpr_wen_q, gpr_wen_d;
   logic [4:0]  gpr_waddr_q, gpr_waddr_d;
   logic [31:0] gpr_wd_q, gpr_wd_d;
   logic        bad_ret_q, bad_ret_d;
   logic        hz0, hz1;

   // Only the returning entry can have ret_write set.
   always_comb begin
      gpr_wen_d   = |ret_write;
      gpr_waddr_d = gpr_waddr_q;
      gpr_wd_d    = gpr_wd_q;
      if (gpr_wen_d) begin
         gpr_waddr_d = ent[ret_tag].rd;
         gpr_wd_d    = ret_data;
      end
      bad_ret_d = bad_ret_q
                | (ret_valid & ~valid_vec[ret_tag])
                | (cancel_valid & ~valid_vec[cancel_tag]);
   end

   // The output-stage compare covers the cycle before the GPR file holds the data.
   always_comb begin
      hz0   = rden0 & (raddr0 != 5'd0) & ((|rd_hit0) | (gpr_wen_q & (gpr_waddr_q == raddr0)));
      hz1   = rden1 & (raddr1 != 5'd0) & ((|rd_hit1) | (gpr_wen_q & (gpr_waddr_q == raddr1)));
      stall = hz0 | hz1;
      full  = &valid_vec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpr_wen_q   <= 1'b0;
         gpr_waddr_q <= 5'd0;
         gpr_wd_q    <= 32'd0;
         bad_ret_q   <= 1'b0;
      end else begin
         gpr_wen_q   <= gpr_wen_d;
         gpr_waddr_q <= gpr_waddr_d;
         gpr_wd_q    <= gpr_wd_d;
         bad_ret_q   <= bad_ret_d;
      end
   end

   assign gpr_wen   = gpr_wen_q;
   assign gpr_waddr = gpr_waddr_q;
   assign gpr_wd    = gpr_wd_q;
   assign bad_ret   = bad_ret_q;

   // Upstream protocol violations; the RTL resolves them as ret > cancel > alloc.
   a_alloc_free: assert property (@(posedge clk) disable iff (rst)
      alloc_valid |-> !valid_vec[alloc_tag]);
   a_ret_cancel_same: assert property (@(posedge clk) disable iff (rst)
      !(ret_valid && cancel_valid && (ret_tag == cancel_tag)));

   // cancel_hit is informational only at this level.
   logic unused_ok;
   assign unused_ok = ^{cancel_hit, ret_hit};

endmodule

// File: doc/el2_dec_nbload_scbd.md
Name: el2_dec_nbload_scbd

Overview:
- Non-blocking load scoreboard and GPR writeback stage. It sits directly upstream of the decode GPR file and drives one of its three write ports (wen/waddr/wd).
- Tracks up to NUM_TAGS outstanding loads by tag, each with its destination register. It raises a decode stall when a source operand targets a pending live destination.
- When load data returns, it writes the data to the GPR file through a registered port.
- It drops returns whose destination was overwritten by a younger instruction (WAW).

Parameters:
- NUM_TAGS, 4, number of outstanding load entries; must be a power of 2, range 2..8.
- TAG_W, $clog2(NUM_TAGS), tag width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- alloc_valid  in  1  load issued non-blocking; allocate entry
- alloc_tag  in  TAG_W  entry index chosen by the LSU
- alloc_rd  in  5  load destination register
- wb_valid  in  1  main pipe writes a GPR this cycle
- wb_rd  in  5  main pipe destination
- cancel_valid  in  1  load killed (flush or bus error); free entry with no write
- cancel_tag  in  TAG_W  entry to cancel
- ret_valid  in  1  load data returned
- ret_tag  in  TAG_W  returning entry
- ret_data  in  32  load data
- rden0, rden1  in  1  decode source operand valid
- raddr0, raddr1  in  5  decode source register
- stall  out  1  operand hazard against a pending load (combinational)
- full  out  1  all entries valid (registered state)
- gpr_wen  out  1  write enable to the GPR file
- gpr_waddr  out  5  write address
- gpr_wd  out  32  write data
- bad_ret  out  1  return or cancel hit an invalid tag (sticky until reset)

Behaviour:
- State per entry:
  - valid: entry allocated, return not yet consumed.
  - live: write still owed to the GPR file.
  - rd[4:0]: destination register.
- Reset (async, rst=1):
  - all valid and live bits = 0.
  - gpr_wen=0, gpr_waddr=0, gpr_wd=0, bad_ret=0.
  - stall=0, full=0.
  - Reset mid-operation discards all outstanding entries silently.
- Allocate, on alloc_valid:
  - valid[tag]=1, rd[tag]=alloc_rd.
  - live[tag] = (alloc_rd != 0). An x0 destination is tracked but never stalls or writes.
- WAW kill on wb_valid with wb_rd != 0: clear live of every valid entry whose rd == wb_rd.
- WAW kill on alloc_valid: clear live of every other valid entry whose rd == alloc_rd.
- Both kills take effect on the next edge.
- Return, on ret_valid with valid[ret_tag]=1:
  - Clears valid[ret_tag] and live[ret_tag] on the next edge.
  - If the entry was live and no same-cycle WAW hits its rd: next cycle gpr_wen=1, gpr_waddr=rd, gpr_wd=ret_data.
  - Otherwise gpr_wen=0. Latency ret -> gpr_wen is exactly 1 cycle.
- Output register:
  - gpr_wen is high for one cycle per write.
  - gpr_waddr and gpr_wd hold their last value when gpr_wen=0.
- Cancel, on cancel_valid with valid[cancel_tag]=1: clears valid and live; no write.
- Invalid tag: ret_valid or cancel_valid targeting an invalid entry is ignored and sets bad_ret.
- Stall:
  - stall = OR over src in {0,1} of: rden_src & raddr_src != 0 & (match against a live entry's rd, or gpr_wen & gpr_waddr == raddr_src).
  - The output-stage compare covers the cycle before the GPR file holds the data.
  - A same-cycle ret_valid does not drop stall; stall drops one cycle after the GPR write.
- full = &valid. The upstream LSU must not allocate when full.
- Illegal, assertion only:
  - alloc to an already-valid tag.
  - ret and cancel to the same tag in one cycle.
  - For illegal cases the RTL priority is ret > cancel > alloc.
- Simultaneous legal events on different tags in one cycle are all applied.

Decomposition:
- Shared package el2_pkg gets:
  - typedef el2_nbload_entry_t {valid, live, rd[4:0]}.
  - constant NBLOAD_TAGS_MAX=8.
- Sub-module el2_dec_nbload_entry holds one entry's state and rd comparators. It is instantiated NUM_TAGS times in a generate loop.
- The top level holds the output register, the stall OR-tree and the bad_ret flop.

Test Plan:
- Alloc tag1 rd=5; rden0=1 raddr0=5 -> stall=1. ret tag1 data=0xDEADBEEF at cycle T -> T+1: gpr_wen=1, waddr=5, wd=0xDEADBEEF, stall=1. At T+2: stall=0.
- Alloc tag0 rd=7; wb_valid wb_rd=7 next cycle; ret tag0 data=0x1234 -> gpr_wen stays 0, entry freed, raddr0=7 gives no stall.
- Alloc tags 0..3 rd=1..4 -> full=1. cancel tag2 -> full=0 next cycle, raddr1=3 no stall, no GPR write for rd=3.
- Alloc tag0 rd=0 -> raddr0=0 never stalls. ret tag0 -> gpr_wen=0.
- ret_valid tag3 with no allocation -> bad_ret=1 persists, no write. Assert rst mid-flight with 2 entries valid -> all outputs 0 next sample, later returns set bad_ret.
- Alloc tag0 rd=9, then alloc tag1 rd=9 -> tag0 live cleared. ret tag0 then ret tag1 data=0x55 -> only one write: waddr=9, wd=0x55.
